decoder_logic_unit: RTL and testbench

- Parametrised, pipelined N-input logic-function unit built on an N-to-2^N one-hot decoder. The output is the OR of the decoder minterms selected by a per-transaction mask.
- Successor to the fixed 2-input decoder gates. Adds:
  - selectable gate mode (AND/OR/NAND/NOR/XOR/XNOR/custom truth table);
  - runtime-programmable mask;
  - valid/ready streaming with backpressure;
  - two registered pipeline stages.

---
 rtl/decoder_logic_unit.sv | 138 +++++++++++++
 tb/tb_decoder_logic_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_logic_unit.sv
// N-input logic unit: one-hot decoder minterms ORed under a per-op mask; 2-cycle latency, 1/cycle throughput.
// Backpressure: output held while out_ready=0, up to 2 transactions buffered, in_ready drops only when both stages are full.
module decoder_logic_unit #(
  parameter int N = 2,
  parameter int M = 2**N,
  parameter logic [M-1:0] RESET_MASK = {{(M-1){1'b1}}, 1'b0}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [2:0]   in_op,
  input  logic         cfg_we,
  input  logic [M-1:0] cfg_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_f,
  output logic [M-1:0] out_minterm
);

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_CUST0 = 3'd6,
    OP_CUST1 = 3'd7
  } op_e;

  typedef struct packed {
    logic [M-1:0] onehot;
    logic [M-1:0] mask;
  } s1_t;

  typedef struct packed {
    logic         f;
    logic [M-1:0] minterm;
  } s2_t;

  logic [M-1:0] and_mask, or_mask, nor_mask, xor_mask;
  logic [M-1:0] sel_mask, dec_onehot;
  logic [M-1:0] cust_mask_q, cust_mask_d;
  logic         s1_vld_q, s1_vld_d;
  logic         s2_vld_q, s2_vld_d;
  s1_t          s1_q, s1_d;
  s2_t          s2_q, s2_d;
  logic         in_fire, s1_load, s2_load;

  // Fixed gate masks expressed as minterm truth tables.
  always_comb begin
    and_mask         = '0;
    and_mask[M-1]    = 1'b1;
    or_mask          = '1;
    or_mask[0]       = 1'b0;
    nor_mask         = '0;
    nor_mask[0]      = 1'b1;
    xor_mask         = '0;
    for (int k = 0; k < M; k++) begin
      xor_mask[k] = ^k;
    end
  end

  always_comb begin
    sel_mask = cust_mask_q;
    case (op_e'(in_op))
      OP_AND:  sel_mask = and_mask;
      OP_OR:   sel_mask = or_mask;
      OP_NAND: sel_mask = ~and_mask;
      OP_NOR:  sel_mask = nor_mask;
      OP_XOR:  sel_mask = xor_mask;
      OP_XNOR: sel_mask = ~xor_mask;
      default: sel_mask = cust_mask_q;
    endcase
  end

  always_comb begin
    dec_onehot       = '0;
    dec_onehot[in_x] = 1'b1;
  end

  assign s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
  assign s1_load  = ~s1_vld_q | s2_load;
  assign in_ready = ~s1_vld_q | ~s2_vld_q | out_ready;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_d        = s1_q;
    s2_vld_d    = s2_vld_q;
    s2_d        = s2_q;
    cust_mask_d = cust_mask_q;

    if (s1_load) begin
      s1_vld_d = in_fire;
    end
    if (in_fire) begin
      s1_d.onehot = dec_onehot;
      s1_d.mask   = sel_mask;
    end

    if (s2_load) begin
      s2_vld_d     = 1'b1;
      s2_d.f       = |(s1_q.onehot & s1_q.mask);
      s2_d.minterm = s1_q.onehot;
    end else if (out_ready) begin
      s2_vld_d = 1'b0;
    end

    // Stage 1 already captured the old mask this cycle, so a same-cycle write only affects later inputs.
    if (cfg_we) begin
      cust_mask_d = cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_q        <= '0;
      s2_vld_q    <= 1'b0;
      s2_q        <= '0;
      cust_mask_q <= RESET_MASK;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_q        <= s1_d;
      s2_vld_q    <= s2_vld_d;
      s2_q        <= s2_d;
      cust_mask_q <= cust_mask_d;
    end
  end

  assign out_valid   = s2_vld_q;
  assign out_f       = s2_q.f;
  assign out_minterm = s2_q.minterm;

endmodule

// File: tb/tb_decoder_logic_unit.sv
// Scoreboard bench for decoder_logic_unit: N=2 instance for gates/backpressure/config/reset/random, N=3 instance for XOR sweep.
module tb_decoder_logic_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid, in_ready, cfg_we, out_valid, out_ready, out_f;
  logic [1:0] in_x;
  logic [2:0] in_op;
  logic [3:0] cfg_mask, out_minterm;

  logic       b_in_valid, b_in_ready, b_cfg_we, b_out_valid, b_out_ready, b_out_f;
  logic [2:0] b_in_x, b_in_op;
  logic [7:0] b_cfg_mask, b_out_minterm;

  typedef struct {
    logic       f;
    logic [7:0] mt;
    int         acc;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [3:0] mask_a = 4'b1110;
  logic [7:0] mask_b = 8'b1111_1110;
  int         cyc_a = 0;
  int         cyc_b = 0;
  bit         lat_chk = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] ops [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};

  decoder_logic_unit #(.N(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_op(in_op),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_minterm(out_minterm)
  );

  decoder_logic_unit #(.N(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_op(b_in_op),
    .cfg_we(b_cfg_we), .cfg_mask(b_cfg_mask), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_f(b_out_f), .out_minterm(b_out_minterm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference truth functions written directly from the gate definitions.
  function automatic logic model_f(input int n, input logic [7:0] x, input logic [2:0] op, input logic [7:0] cm);
    logic all1;
    all1 = (x == 8'((1 << n) - 1));
    case (op)
      3'd0:    return all1;
      3'd1:    return x != 8'd0;
      3'd2:    return !all1;
      3'd3:    return x == 8'd0;
      3'd4:    return ^x;
      3'd5:    return ~^x;
      default: return cm[x[2:0]];
    endcase
  endfunction

  // Monitors sample 1 time unit before each rising edge.
  always begin
    @(negedge clk); #4;
    cyc_a++;
    if (rst) begin
      qa.delete();
      mask_a = 4'b1110;
    end else begin
      if (out_valid) begin
        if (qa.size() == 0) begin
          chk("a_spurious_out", 64'(out_valid), 64'd0);
        end else begin
          chk("a_out_f", 64'(out_f), 64'(qa[0].f));
          chk("a_out_minterm", 64'(out_minterm), 64'(qa[0].mt));
          if (out_ready) begin
            if (lat_chk) chk("a_latency", 64'(cyc_a - qa[0].acc), 64'd2);
            void'(qa.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        qa.push_back('{f: model_f(2, 8'(in_x), in_op, 8'(mask_a)), mt: 8'(1 << in_x), acc: cyc_a});
      if (cfg_we) mask_a = cfg_mask;
    end
  end

  always begin
    @(negedge clk); #4;
    cyc_b++;
    if (rst) begin
      qb.delete();
      mask_b = 8'b1111_1110;
    end else begin
      if (b_out_valid) begin
        if (qb.size() == 0) begin
          chk("b_spurious_out", 64'(b_out_valid), 64'd0);
        end else begin
          chk("b_out_f", 64'(b_out_f), 64'(qb[0].f));
          chk("b_out_minterm", 64'(b_out_minterm), 64'(qb[0].mt));
          if (b_out_ready) void'(qb.pop_front());
        end
      end
      if (b_in_valid && b_in_ready)
        qb.push_back('{f: model_f(3, 8'(b_in_x), b_in_op, mask_b), mt: 8'(1 << b_in_x), acc: cyc_b});
      if (b_cfg_we) mask_b = b_cfg_mask;
    end
  end

  task automatic send_a(input logic [1:0] x, input logic [2:0] op);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_op = op;
    #4;
    while (!in_ready && n < 200) begin
      @(negedge clk); #4;
      n++;
    end
    if (n >= 200) chk("a_send_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_b(input logic [2:0] x, input logic [2:0] op);
    int n = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_x = x; b_in_op = op;
    #4;
    while (!b_in_ready && n < 200) begin
      @(negedge clk); #4;
      n++;
    end
    if (n >= 200) chk("b_send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain_a();
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100 && qa.size() != 0; i++) @(negedge clk);
    chk("a_drained", 64'(qa.size()), 64'd0);
  endtask

  task automatic drain_b();
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 100 && qb.size() != 0; i++) @(negedge clk);
    chk("b_drained", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    int n_acc;
    int guard;
    in_valid = 1'b0; in_x = '0; in_op = '0; cfg_we = 1'b0; cfg_mask = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_x = '0; b_in_op = '0; b_cfg_we = 1'b0; b_cfg_mask = '0; b_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_f", 64'(out_f), 64'd0);
    chk("rst_out_minterm", 64'(out_minterm), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);

    // Gate truth tables, streamed back to back with out_ready held high.
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int x = 0; x < 4; x++) send_a(2'(x), ops[i]);
      drain_a();
    end
    lat_chk = 1'b0;

    // Backpressure: two accepted, third stalls until out_ready rises.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_x = 2'd0; in_op = 3'd2;
    #4 chk("bp_acc0", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_x = 2'd1;
    #4 chk("bp_acc1", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_x = 2'd3;
    #4 chk("bp_stall0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      chk("bp_stall", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #4 chk("bp_release", 64'(in_ready), 64'd1);
    drain_a();

    // Custom mask write coincident with a CUSTOM accept uses the old mask.
    @(negedge clk);
    in_valid = 1'b1; in_x = 2'd2; in_op = 3'd6; cfg_we = 1'b1; cfg_mask = 4'b0100;
    #4 chk("cust_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    send_a(2'd1, 3'd7);
    send_a(2'd2, 3'd6);
    drain_a();

    // Reset with two transactions in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_x = 2'd1; in_op = 3'd1;
    @(negedge clk);
    in_x = 2'd3;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_a(2'd1, 3'd6);
    send_a(2'd0, 3'd6);
    drain_a();

    // N=3 XOR sweep.
    for (int x = 0; x < 8; x++) send_b(3'(x), 3'd4);
    drain_b();

    // Random traffic with random backpressure and occasional mask writes.
    n_acc = 0;
    guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = 2'($urandom_range(0, 3));
      in_op     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_mask  = 4'($urandom_range(0, 15));
      #4;
      if (in_valid && in_ready) n_acc++;
      guard++;
    end
    chk("rand_accepts", 64'(n_acc), 64'd1000);
    drain_a();

    repeat (3) @(negedge clk);
    chk("final_a_empty", 64'(qa.size()), 64'd0);
    chk("final_b_empty", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
